// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file with NRPORTS registered read ports,
//            NWPORTS prioritised write ports (highest index wins),
//            write-to-read bypass and a per-register pending scoreboard.
//            Register 0 is hardwired to zero.
// Options  : RF_RESET_INDEX_EN - when defined, reset loads bank[i] = i.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32,
  parameter int NRPORTS   = 2,
  parameter int NWPORTS   = 2,
  localparam int AW       = $clog2(NUMREGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NRPORTS-1:0]           re_i,
  input  logic [NRPORTS*AW-1:0]        raddr_i,
  output logic [NRPORTS*DATAWIDTH-1:0] rdata_o,
  output logic [NRPORTS-1:0]           rvalid_o,
  input  logic [NWPORTS-1:0]           we_i,
  input  logic [NWPORTS*AW-1:0]        waddr_i,
  input  logic [NWPORTS*DATAWIDTH-1:0] wdata_i,
  input  logic                         rsv_i,
  input  logic [AW-1:0]                rsv_addr_i,
  output logic [NUMREGS-1:0]           busy_o
);

  logic [DATAWIDTH-1:0] bank [NUMREGS];
  logic [NUMREGS-1:0]   busy;
  logic [NUMREGS-1:0]   busy_nxt;
  logic [NRPORTS-1:0]   byp_hit;
  logic [DATAWIDTH-1:0] byp_data [NRPORTS];
  logic [DATAWIDTH-1:0] rdata_q [NRPORTS];
  logic [NRPORTS-1:0]   rvalid_q;

  // Bank update: reset image, otherwise writes in port order so the highest index wins.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUMREGS; i++) begin
`ifdef RF_RESET_INDEX_EN
        bank[i] <= DATAWIDTH'(i);
`else
        bank[i] <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NWPORTS; k++) begin
        if (we_i[k] && (waddr_i[k*AW +: AW] != '0)) begin
          bank[waddr_i[k*AW +: AW]] <= wdata_i[k*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  // Next scoreboard state: writes clear, a reserve applied afterwards wins; entry 0 never busy.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWPORTS; k++) begin
      if (we_i[k]) begin
        busy_nxt[waddr_i[k*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_i) begin
      busy_nxt[rsv_addr_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; reset drops every outstanding reservation.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Per read port, find the highest-index same-cycle write to the read address.
  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      byp_hit[p]  = 1'b0;
      byp_data[p] = '0;
      for (int k = 0; k < NWPORTS; k++) begin
        if (we_i[k] && (waddr_i[k*AW +: AW] == raddr_i[p*AW +: AW])) begin
          byp_hit[p]  = 1'b1;
          byp_data[p] = wdata_i[k*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  // Registered read ports; validity uses the scoreboard as it was before this cycle's reserve.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NRPORTS; p++) begin
      if (!rst_i || !re_i[p]) begin
        rdata_q[p]  <= '0;
        rvalid_q[p] <= 1'b0;
      end else if (raddr_i[p*AW +: AW] == '0) begin
        rdata_q[p]  <= '0;
        rvalid_q[p] <= 1'b1;
      end else if (byp_hit[p]) begin
        rdata_q[p]  <= byp_data[p];
        rvalid_q[p] <= 1'b1;
      end else begin
        rdata_q[p]  <= bank[raddr_i[p*AW +: AW]];
        rvalid_q[p] <= ~busy[raddr_i[p*AW +: AW]];
      end
    end
  end

  generate
    for (genvar p = 0; p < NRPORTS; p++) begin : g_rport
      assign rdata_o[p*DATAWIDTH +: DATAWIDTH] = rdata_q[p];
    end
  endgenerate

  assign rvalid_o = rvalid_q;
  assign busy_o   = busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Scoreboard bench for regfile_mp: stimulus pushes hand-computed
//            expectations, a monitor pops and compares one per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int NUMREGS   = 32;
  localparam int DATAWIDTH = 32;
  localparam int NRPORTS   = 2;
  localparam int NWPORTS   = 2;
  localparam int AW        = 5;

  logic                         clk_i;
  logic                         rst_i;
  logic [NRPORTS-1:0]           re_i;
  logic [NRPORTS*AW-1:0]        raddr_i;
  logic [NRPORTS*DATAWIDTH-1:0] rdata_o;
  logic [NRPORTS-1:0]           rvalid_o;
  logic [NWPORTS-1:0]           we_i;
  logic [NWPORTS*AW-1:0]        waddr_i;
  logic [NWPORTS*DATAWIDTH-1:0] wdata_i;
  logic                         rsv_i;
  logic [AW-1:0]                rsv_addr_i;
  logic [NUMREGS-1:0]           busy_o;

  regfile_mp #(
    .NUMREGS  (NUMREGS),
    .DATAWIDTH(DATAWIDTH),
    .NRPORTS  (NRPORTS),
    .NWPORTS  (NWPORTS)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .re_i      (re_i),
    .raddr_i   (raddr_i),
    .rdata_o   (rdata_o),
    .rvalid_o  (rvalid_o),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .rsv_i     (rsv_i),
    .rsv_addr_i(rsv_addr_i),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic        v0;
    logic [31:0] d1;
    logic        v1;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Value a register holds right after reset.
  function automatic logic [31:0] rv(input int a);
`ifdef RF_RESET_INDEX_EN
    return 32'(a);
`else
    return 32'(a) & 32'h0;
`endif
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Inputs for the next clock edge, applied on the falling edge.
  task automatic drive(input bit rst, input bit [1:0] we, input int wa0, input logic [31:0] wd0,
                       input int wa1, input logic [31:0] wd1, input bit [1:0] re,
                       input int ra0, input int ra1, input bit rsv, input int rsa);
    @(negedge clk_i);
    rst_i      = rst;
    we_i       = we;
    waddr_i    = {AW'(wa1), AW'(wa0)};
    wdata_i    = {wd1, wd0};
    re_i       = re;
    raddr_i    = {AW'(ra1), AW'(ra0)};
    rsv_i      = rsv;
    rsv_addr_i = AW'(rsa);
  endtask

  task automatic ex(input string nm, input logic [31:0] d0, input logic v0,
                    input logic [31:0] d1, input logic v1, input logic [31:0] b);
    exp_t e;
    e.name = nm; e.d0 = d0; e.v0 = v0; e.d1 = d1; e.v1 = v1; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp({e.name, ".rdata0"},  rdata_o[31:0],  e.d0);
        cmp({e.name, ".rvalid0"}, 32'(rvalid_o[0]), 32'(e.v0));
        cmp({e.name, ".rdata1"},  rdata_o[63:32], e.d1);
        cmp({e.name, ".rvalid1"}, 32'(rvalid_o[1]), 32'(e.v1));
        cmp({e.name, ".busy"},    busy_o,         e.busy);
      end
    end
  end

  initial begin
    rst_i = 1'b0; we_i = '0; waddr_i = '0; wdata_i = '0;
    re_i = '0; raddr_i = '0; rsv_i = 1'b0; rsv_addr_i = '0;

    // Reset held two cycles while reading and writing: everything stays zero.
    drive(0, 2'b01, 7, 32'h1234, 0, 0, 2'b11, 5, 5, 1, 6);
    ex("rst0", 0, 0, 0, 0, 0);
    drive(0, 2'b01, 7, 32'h1234, 0, 0, 2'b11, 5, 5, 1, 6);
    ex("rst1", 0, 0, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 5, 5, 0, 0);
    ex("rst_rd5", rv(5), 1, rv(5), 1, 0);

    // Basic write then read on both ports.
    drive(1, 2'b01, 7, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0, 0, 0);
    ex("wr_r7", 0, 0, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 7, 7, 0, 0);
    ex("rd_r7", 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);

    // Two writes to r3 in one cycle, bypassed to a read: port 1 wins.
    drive(1, 2'b11, 3, 32'h11, 3, 32'h22, 2'b01, 3, 0, 0, 0);
    ex("byp_r3", 32'h22, 1, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0);
    ex("rd_r3", 32'h22, 1, 32'h22, 1, 0);

    // r0 ignores writes and reserves.
    drive(1, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 2'b10, 0, 0, 0, 0);
    ex("wr_r0", 0, 0, 0, 1, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 1, 0);
    ex("rsv_r0", 0, 1, 0, 1, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    ex("rd_r0", 0, 1, 0, 1, 0);

    // Scoreboard: reserve r9, read while pending, write clears it.
    drive(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 9);
    ex("rsv_r9", 0, 0, 0, 0, 32'h0000_0200);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b01, 9, 0, 0, 0);
    ex("rd_r9_pend", rv(9), 0, 0, 0, 32'h0000_0200);
    drive(1, 2'b01, 9, 32'h42, 0, 0, 2'b10, 0, 9, 0, 0);
    ex("wr_r9", 0, 0, 32'h42, 1, 0);

    // Reserve and write r9 together: stays busy, bank takes the data.
    drive(1, 2'b01, 9, 32'h77, 0, 0, 2'b01, 9, 0, 1, 9);
    ex("rsvwr_r9", 32'h77, 1, 0, 0, 32'h0000_0200);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b10, 0, 9, 0, 0);
    ex("rd_r9_new", 0, 0, 32'h77, 0, 32'h0000_0200);

    // Read and reserve r10 in one cycle: the read sees the old (free) state.
    drive(1, 2'b00, 0, 0, 0, 0, 2'b01, 10, 0, 1, 10);
    ex("rsvrd_r10", rv(10), 1, 0, 0, 32'h0000_0600);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 10, 10, 0, 0);
    ex("rd_r10_pend", rv(10), 0, rv(10), 0, 32'h0000_0600);

    // Reset mid-operation.
    drive(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 4);
    ex("rsv_r4", 0, 0, 0, 0, 32'h0000_0610);
    drive(1, 2'b01, 4, 32'h55, 0, 0, 2'b01, 4, 0, 0, 0);
    ex("wr_r4", 32'h55, 1, 0, 0, 32'h0000_0600);
    drive(0, 2'b01, 4, 32'h99, 0, 0, 2'b11, 4, 9, 1, 12);
    ex("rst_mid", 0, 0, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 4, 9, 0, 0);
    ex("post_rst_r4r9", rv(4), 1, rv(9), 1, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b11, 7, 3, 0, 0);
    ex("post_rst_r7r3", rv(7), 1, rv(3), 1, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk_i);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
